// File: rtl/reg_file_sb.sv
// reg_file_sb
//   Architectural register file with NUM_READ combinational read ports, one
//   synchronous write port, a per-register pending-write scoreboard and a
//   sequential bulk-clear engine. x0 reads as zero and is never written or
//   marked busy.
//
//   Optional feature macro: REGFILE_BYPASS_EN
//     defined   : write-first bypass on RD, and HAZ is masked for the register
//                 being written in the same cycle.
//     undefined : RD returns the pre-write value, HAZ = busy[AD_i].
//
// Ports
//   clk, rst_n         clock (rising edge), async active-low reset
//   AD / RD / HAZ      packed read address / data / hazard flag per port
//   AD3, WE3, WD3      write port
//   BUSY_AD, BUSY_SET  mark destination register as pending
//   CLR_REQ            start bulk clear of registers 1..DEPTH-1
//   CLR_BUSY           clear engine active (also high from reset until done)
//   a0                 raw contents of DEBUG_REG, never bypassed
module reg_file_sb #(
    parameter int ADDRESS_WIDTH = 5,
    parameter int DATA_WIDTH    = 32,
    parameter int NUM_READ      = 2,
    parameter int DEBUG_REG     = 10
) (
    input  logic                               clk,
    input  logic                               rst_n,
    input  logic [NUM_READ*ADDRESS_WIDTH-1:0]  AD,
    output logic [NUM_READ*DATA_WIDTH-1:0]     RD,
    output logic [NUM_READ-1:0]                HAZ,
    input  logic [ADDRESS_WIDTH-1:0]           AD3,
    input  logic                               WE3,
    input  logic [DATA_WIDTH-1:0]              WD3,
    input  logic [ADDRESS_WIDTH-1:0]           BUSY_AD,
    input  logic                               BUSY_SET,
    input  logic                               CLR_REQ,
    output logic                               CLR_BUSY,
    output logic [DATA_WIDTH-1:0]              a0
);

    localparam int                     DEPTH    = 2**ADDRESS_WIDTH;
    localparam logic [ADDRESS_WIDTH-1:0] PTR_LAST = {ADDRESS_WIDTH{1'b1}};
    localparam logic [ADDRESS_WIDTH-1:0] PTR_INIT = ADDRESS_WIDTH'(1);
    localparam logic [ADDRESS_WIDTH-1:0] DBG_IDX  = ADDRESS_WIDTH'(DEBUG_REG);

    typedef enum logic {IDLE = 1'b0, CLEAR = 1'b1} state_t;

    state_t                   state, state_nxt;
    logic [ADDRESS_WIDTH-1:0] ptr;
    logic [DEPTH-1:0]         busy;
    logic [DATA_WIDTH-1:0]    mem [DEPTH];
    logic                     idle;
    logic                     wr_ok;

    assign idle  = (state == IDLE);
    // All external commands are ignored while the clear engine runs.
    assign wr_ok = WE3 && (AD3 != '0) && idle;

    // ---------------- clear FSM ----------------
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) state <= CLEAR;
        else        state <= state_nxt;
    end

    always_comb begin
        state_nxt = state;
        case (state)
            IDLE:    if (CLR_REQ)           state_nxt = CLEAR;
            CLEAR:   if (ptr == PTR_LAST)   state_nxt = IDLE;
            default:                        state_nxt = IDLE;
        endcase
    end

    always_comb begin
        CLR_BUSY = (state == CLEAR);
    end

    // ---------------- pointer + scoreboard ----------------
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            ptr  <= PTR_INIT;
            busy <= '0;
        end else if (idle) begin
            if (CLR_REQ) begin
                ptr  <= PTR_INIT;
                busy <= '0;
            end else begin
                if (wr_ok) busy[AD3] <= 1'b0;
                // Set is applied last so a newly issued producer wins over
                // a completing write to the same register.
                if (BUSY_SET && (BUSY_AD != '0)) busy[BUSY_AD] <= 1'b1;
            end
        end else begin
            ptr <= ptr + 1'b1;
        end
    end

    // ---------------- storage (no reset; cleared by the engine) ----------------
    always_ff @(posedge clk) begin
        if (!idle)      mem[ptr] <= '0;
        else if (wr_ok) mem[AD3] <= WD3;
    end

    // ---------------- read ports ----------------
    for (genvar i = 0; i < NUM_READ; i++) begin : g_rd
        logic [ADDRESS_WIDTH-1:0] ad;
        logic                     byp;

        assign ad = AD[i*ADDRESS_WIDTH +: ADDRESS_WIDTH];
`ifdef REGFILE_BYPASS_EN
        assign byp = wr_ok && (AD3 == ad);
`else
        assign byp = 1'b0;
`endif
        assign RD[i*DATA_WIDTH +: DATA_WIDTH] = (ad == '0) ? '0 :
                                                byp        ? WD3 : mem[ad];
        assign HAZ[i] = idle && busy[ad] && !byp;
    end

    assign a0 = (DBG_IDX == '0) ? '0 : mem[DBG_IDX];

endmodule
